dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data memory between the core load/store port and a DMA/debug master.
//  Sits between the core datapath (ALU address, rs2 store data, funct3 size) and dataMemory.
//  Grants one requester per cycle; the access completes in the granted cycle.
//  Raises core_stall so the core holds PC and suppresses writeback while it is denied.
// PARAMETERS
//  ADDR_W         32  address width, both ports and memory side
//  DATA_W         32  data width
//  DMA_BURST_MAX  8   max consecutive locked DMA grants before the core may win (>=1)
//  CNT_W          16  width of the saturating conflict counter
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  rst          in   1       synchronous reset, active-high
//  core_req     in   1       core access request (memRead|memWrite)
//  core_we      in   1       1 = store, 0 = load
//  core_addr    in   ADDR_W  byte address
//  core_wdata   in   DATA_W  store data
//  core_funct3  in   3       access size/sign, passed through unchanged
//  core_gnt     out  1       core owns memory this cycle
//  core_rdata   out  DATA_W  load data, valid when core_gnt & ~core_we
//  core_stall   out  1       core_req & ~core_gnt
//  dma_req      in   1       DMA access request
//  dma_lock     in   1       DMA requests burst ownership
//  dma_we / dma_addr / dma_wdata / dma_funct3   in   as core_*
//  dma_gnt      out  1       DMA owns memory this cycle
//  dma_rdata    out  DATA_W  load data, valid when dma_gnt & ~dma_we
//  mem_read     out  1       to dataMemory memRead
//  mem_write    out  1       to dataMemory memWrite
//  mem_addr / mem_wdata / mem_funct3   out   muxed from the granted port
//  mem_rdata    in   DATA_W  from dataMemory (combinational read)
//  conflict_cnt out  CNT_W   cycles in which both ports requested, saturating
// BEHAVIOUR
//  - Registered state: mode {RR, LOCK}, last_owner (0=core, 1=dma), burst_cnt, conflict_cnt.
//  - Grants are combinational from the current inputs and registered state. Zero added latency.
//  - At most one of core_gnt/dma_gnt is high. A grant is never given without a request.
//  - mem_read  = gnt & ~we of the owner. mem_write = gnt & we of the owner.
//  - No grant: both are 0, and mem_addr/mem_wdata/mem_funct3 carry the core_* values.
//  - core_rdata = dma_rdata = mem_rdata. They are meaningful only in a load-granted cycle.
//  - RR mode:
//    - A single requester is granted.
//    - Both requesting: grant the port that is not last_owner.
//    - DMA granted with dma_lock=1 -> next mode LOCK, burst_cnt=1.
//  - LOCK mode:
//    - dma_req & dma_lock & burst_cnt<DMA_BURST_MAX: grant DMA regardless of core_req, and burst_cnt++.
//    - Otherwise arbitrate as RR this cycle. Next mode RR, burst_cnt=0.
//    - Burst exhausted with core waiting -> core wins, because last_owner=dma.
//  - last_owner is updated only in cycles with a grant.
//  - conflict_cnt += 1 when core_req & dma_req and rst=0. It holds at 2^CNT_W-1.
//  - Requests may change any cycle. No request needs to be held, and dropping a request costs nothing.
//  - Reset (sync, any state including mid-burst):
//    - Registers: mode=RR, last_owner=1, burst_cnt=0, conflict_cnt=0.
//    - While rst=1, all grants, mem_read and mem_write are forced to 0, and core_stall=core_req.
//    - First conflict after reset goes to the core.
// TESTING
//  1. Reset, then core_req=1, we=0, addr=0x10 alone -> core_gnt=1 same cycle, mem_read=1, mem_addr=0x10, core_stall=0.
//  2. Both request loads, lock=0, for 3 cycles after reset -> grants core, dma, core; core_stall=0,1,0; conflict_cnt=3.
//  3. Both request continuously, dma_lock=1, DMA_BURST_MAX=8 -> cycle0 core, cycles1-8 dma, cycle9 core; core_stall high cycles1-8.
//  4. Locked burst, dma_lock drops after 3 DMA grants with core waiting -> core_gnt next cycle, mode back to RR.
//  5. rst=1 for one cycle mid-LOCK (burst_cnt=4) -> no grant that cycle; next conflict granted to core; burst restarts at 1.
//  6. CNT_W=4, 20 conflict cycles; store dma_we=1, dma_wdata=0xA5A5A5A5 -> conflict_cnt=15 held; mem_write=1 with dma data when granted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store port and a DMA/debug master.
// Single-cycle combinational grant, alternating on conflict, with bounded DMA lock bursts.
module dmem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DMA_BURST_MAX = 8,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_funct3,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [2:0]        dma_funct3,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int BW = $clog2(DMA_BURST_MAX + 1);
  localparam logic [BW-1:0] BMAX = BW'(DMA_BURST_MAX);

  typedef enum logic {RR = 1'b0, LOCK = 1'b1} mode_t;

  mode_t            r_mode, w_mode_nxt;
  logic             r_last, w_last_nxt;
  logic [BW-1:0]    r_burst, w_burst_nxt;
  logic [CNT_W-1:0] r_conf, w_conf_nxt;

  logic w_lock_win, w_rr_dma, w_core_gnt, w_dma_gnt;

  // Locked DMA beats bypass fairness; everything else alternates on last_owner.
  assign w_lock_win = (r_mode == LOCK) & dma_req & dma_lock & (r_burst < BMAX);
  assign w_rr_dma   = dma_req & (~core_req | ~r_last);
  assign w_dma_gnt  = ~rst & (w_lock_win | w_rr_dma);
  assign w_core_gnt = ~rst & ~w_lock_win & core_req & ~w_rr_dma;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= RR;
      r_last  <= 1'b1;
      r_burst <= '0;
      r_conf  <= '0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_last  <= w_last_nxt;
      r_burst <= w_burst_nxt;
      r_conf  <= w_conf_nxt;
    end
  end

  always_comb begin
    w_mode_nxt  = RR;
    w_burst_nxt = '0;
    w_last_nxt  = r_last;
    w_conf_nxt  = r_conf;
    if (core_req && dma_req && r_conf != '1) w_conf_nxt = r_conf + 1'b1;
    if (w_core_gnt || w_dma_gnt) w_last_nxt = w_dma_gnt;
    if (w_lock_win) begin
      w_mode_nxt  = LOCK;
      w_burst_nxt = r_burst + 1'b1;
    end else if (r_mode == RR && w_dma_gnt && dma_lock) begin
      w_mode_nxt  = LOCK;
      w_burst_nxt = BW'(1);
    end
  end

  always_comb begin
    core_gnt     = w_core_gnt;
    dma_gnt      = w_dma_gnt;
    core_stall   = core_req & ~w_core_gnt;
    core_rdata   = mem_rdata;
    dma_rdata    = mem_rdata;
    conflict_cnt = r_conf;
    mem_read     = (w_core_gnt & ~core_we) | (w_dma_gnt & ~dma_we);
    mem_write    = (w_core_gnt & core_we) | (w_dma_gnt & dma_we);
    mem_addr     = core_addr;
    mem_wdata    = core_wdata;
    mem_funct3   = core_funct3;
    if (w_dma_gnt) begin
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
      mem_funct3 = dma_funct3;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic checked against
// a behavioural model of ownership, burst length and conflict count.
module tb_dmem_arbiter;
  localparam int BMAX = 8;
  localparam int CMAX = 15;

  logic        clk, rst;
  logic        core_req, core_we, core_gnt, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [2:0]  core_funct3;
  logic        dma_req, dma_lock, dma_we, dma_gnt;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [2:0]  dma_funct3;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;
  logic [3:0]  conflict_cnt;

  int total = 0, bad = 0;
  bit m_last;
  int m_burst, m_conf;
  bit e_cg, e_dg, e_lockwin;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DMA_BURST_MAX(BMAX), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_funct3(core_funct3), .core_gnt(core_gnt), .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_funct3(dma_funct3), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // m_burst counts locked DMA grants in the current burst; 0 means no burst open.
  function automatic void model_eval();
    e_cg = 0; e_dg = 0; e_lockwin = 0;
    if (!rst) begin
      if (m_burst > 0 && m_burst < BMAX && dma_req && dma_lock) begin
        e_lockwin = 1; e_dg = 1;
      end else if (core_req && dma_req) begin
        if (m_last) e_cg = 1; else e_dg = 1;
      end else begin
        e_cg = core_req; e_dg = dma_req;
      end
    end
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_last = 1; m_burst = 0; m_conf = 0;
    end else begin
      if (core_req && dma_req && m_conf < CMAX) m_conf++;
      if (e_cg || e_dg) m_last = e_dg;
      if (e_lockwin) m_burst++;
      else if (m_burst == 0 && e_dg && dma_lock) m_burst = 1;
      else m_burst = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; dma_req = 0; dma_lock = 0; dma_we = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; core_req = 1; dma_req = 1; dma_lock = 1; #1;
    total++; if (core_gnt !== 0 || dma_gnt !== 0) begin bad++; $display("FAIL rst_gnt core=%b dma=%b want 0 0", core_gnt, dma_gnt); end
    total++; if (mem_read !== 0 || mem_write !== 0) begin bad++; $display("FAIL rst_mem rd=%b wr=%b want 0 0", mem_read, mem_write); end
    total++; if (core_stall !== 1) begin bad++; $display("FAIL rst_stall got=%b want 1", core_stall); end
    tick(); rst = 0; idle(); #1;
    total++; if (conflict_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d want 0", conflict_cnt); end
  endtask

  task automatic test_core_alone();
    do_reset();
    core_req = 1; core_we = 0; core_addr = 32'h10; mem_rdata = 32'h1234_5678; #1;
    total++; if (core_gnt !== 1) begin bad++; $display("FAIL t1_gnt got=%b want 1", core_gnt); end
    total++; if (mem_read !== 1 || mem_write !== 0) begin bad++; $display("FAIL t1_rw rd=%b wr=%b want 1 0", mem_read, mem_write); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL t1_addr got=%h want 10", mem_addr); end
    total++; if (core_stall !== 0) begin bad++; $display("FAIL t1_stall got=%b want 0", core_stall); end
    total++; if (core_rdata !== 32'h1234_5678) begin bad++; $display("FAIL t1_rdata got=%h want 12345678", core_rdata); end
    tick();
  endtask

  task automatic test_rr();
    bit exp_c [3] = '{1, 0, 1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      core_req = 1; dma_req = 1; dma_lock = 0; core_we = 0; dma_we = 0; #1;
      total++; if (core_gnt !== exp_c[i] || dma_gnt !== !exp_c[i]) begin bad++; $display("FAIL t2_gnt%0d core=%b dma=%b want %b", i, core_gnt, dma_gnt, exp_c[i]); end
      total++; if (core_stall !== !exp_c[i]) begin bad++; $display("FAIL t2_stall%0d got=%b want %b", i, core_stall, !exp_c[i]); end
      tick();
    end
    idle(); #1;
    total++; if (conflict_cnt !== 4'd3) begin bad++; $display("FAIL t2_cnt got=%0d want 3", conflict_cnt); end
  endtask

  task automatic test_burst();
    bit exp_d;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      core_req = 1; dma_req = 1; dma_lock = 1; #1;
      exp_d = (i >= 1 && i <= BMAX);
      total++; if (dma_gnt !== exp_d || core_gnt !== !exp_d) begin bad++; $display("FAIL t3_gnt%0d dma=%b core=%b want dma=%b", i, dma_gnt, core_gnt, exp_d); end
      total++; if (core_stall !== exp_d) begin bad++; $display("FAIL t3_stall%0d got=%b want %b", i, core_stall, exp_d); end
      tick();
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      core_req = 1; dma_req = 1; dma_lock = 1; tick();
    end
    dma_lock = 0; #1;
    total++; if (core_gnt !== 1 || dma_gnt !== 0) begin bad++; $display("FAIL t4_core core=%b dma=%b want 1 0", core_gnt, dma_gnt); end
    tick();
    dma_lock = 1; #1;
    total++; if (dma_gnt !== 1) begin bad++; $display("FAIL t4_rr got=%b want 1", dma_gnt); end
    tick(); idle();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      core_req = 1; dma_req = 1; dma_lock = 1; tick();
    end
    rst = 1; #1;
    total++; if (core_gnt !== 0 || dma_gnt !== 0 || mem_read !== 0) begin bad++; $display("FAIL t5_rst core=%b dma=%b rd=%b want 0", core_gnt, dma_gnt, mem_read); end
    total++; if (core_stall !== 1) begin bad++; $display("FAIL t5_stall got=%b want 1", core_stall); end
    tick(); rst = 0; #1;
    total++; if (core_gnt !== 1) begin bad++; $display("FAIL t5_first got=%b want 1", core_gnt); end
    tick();
    for (int i = 0; i <= BMAX; i++) begin
      #1;
      total++; if (dma_gnt !== (i < BMAX)) begin bad++; $display("FAIL t5_burst%0d got=%b want %b", i, dma_gnt, (i < BMAX)); end
      tick();
    end
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    core_we = 0; dma_we = 1; dma_wdata = 32'hA5A5_A5A5; dma_addr = 32'h40;
    for (int i = 0; i < 20; i++) begin
      core_req = 1; dma_req = 1; dma_lock = 0; #1;
      model_eval();
      total++; if (dma_gnt !== e_dg) begin bad++; $display("FAIL t6_gnt%0d got=%b want %b", i, dma_gnt, e_dg); end
      if (e_dg) begin
        total++; if (mem_write !== 1 || mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL t6_wr%0d wr=%b data=%h want 1 a5a5a5a5", i, mem_write, mem_wdata); end
      end
      tick();
    end
    idle(); #1;
    total++; if (conflict_cnt !== 4'd15) begin bad++; $display("FAIL t6_cnt got=%0d want 15", conflict_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] ea, ew;
    logic [2:0]  ef;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      core_req = $urandom_range(0, 3) != 0; core_we = $urandom_range(0, 1);
      core_addr = $urandom; core_wdata = $urandom; core_funct3 = 3'($urandom_range(0, 7));
      dma_req = $urandom_range(0, 3) != 0; dma_lock = $urandom_range(0, 4) != 0; dma_we = $urandom_range(0, 1);
      dma_addr = $urandom; dma_wdata = $urandom; dma_funct3 = 3'($urandom_range(0, 7));
      mem_rdata = $urandom; #1;
      model_eval();
      ea = e_dg ? dma_addr : core_addr; ew = e_dg ? dma_wdata : core_wdata; ef = e_dg ? dma_funct3 : core_funct3;
      total++; if (core_gnt !== e_cg || dma_gnt !== e_dg) begin bad++; $display("FAIL rnd_gnt%0d core=%b dma=%b want %b %b", i, core_gnt, dma_gnt, e_cg, e_dg); end
      total++; if (mem_read !== ((e_cg && !core_we) || (e_dg && !dma_we)) || mem_write !== ((e_cg && core_we) || (e_dg && dma_we))) begin
        bad++; $display("FAIL rnd_rw%0d rd=%b wr=%b", i, mem_read, mem_write); end
      total++; if (mem_addr !== ea || mem_wdata !== ew || mem_funct3 !== ef) begin bad++; $display("FAIL rnd_mux%0d addr=%h want %h", i, mem_addr, ea); end
      total++; if (core_stall !== (core_req && !e_cg)) begin bad++; $display("FAIL rnd_stall%0d got=%b", i, core_stall); end
      total++; if (conflict_cnt !== 4'(m_conf)) begin bad++; $display("FAIL rnd_cnt%0d got=%0d want %0d", i, conflict_cnt, m_conf); end
      total++; if (core_rdata !== mem_rdata || dma_rdata !== mem_rdata) begin bad++; $display("FAIL rnd_rdata%0d got=%h want %h", i, core_rdata, mem_rdata); end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    m_last = 1; m_burst = 0; m_conf = 0;
    rst = 1; idle();
    core_addr = 0; core_wdata = 0; core_funct3 = 0;
    dma_addr = 0; dma_wdata = 0; dma_funct3 = 0; mem_rdata = 0;
    @(negedge clk);
    test_reset();
    test_core_alone();
    test_rr();
    test_burst();
    test_lock_drop();
    test_reset_mid_lock();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
